// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus signals seen by a single slave, with master and slave views.
interface ahbl_sram_slave_if;

  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastrlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastrlock, hwdata,
    output hready, hresp, hrdata
  );

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastrlock, hwdata,
    input  hready, hresp, hrdata
  );

endinterface

// File: rtl/ahbl_strb_gen.sv
// Byte-lane strobe and size/alignment error decode for one AHB-Lite transfer.
module ahbl_strb_gen
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       err
);

  // Sizes wider than a word are illegal on this 32-bit slave.
  always_comb begin
    strb = 4'b0000;
    err  = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb = 4'b0011 << {addr_lo[1], 1'b0};
        err  = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb = 4'b1111;
        err  = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave front end for a single-port synchronous SRAM with
// programmable data-phase wait states and two-cycle ERROR responses.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahbl_sram_slave_if.slave      bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  state_t                state, state_next;
  logic [1:0]            cnt, cnt_next;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_q;
  logic [3:0]            strb;
  logic                  align_err;
  logic                  ready_int, accept, first;
  logic                  en_int, we_int, resp_int, capture;
  logic                  unused_bits;

  ahbl_strb_gen u_strb_gen (
    .hsize   (bus.hsize),
    .addr_lo (bus.haddr[1:0]),
    .strb    (strb),
    .err     (align_err)
  );

  assign unused_bits = &{1'b0, bus.hburst, bus.hprot, bus.hmastrlock,
                         bus.htrans[0], bus.haddr[31:ADDR_WIDTH]};

  assign ready_int = (state == ST_RD || state == ST_ERR1) ? 1'b0 :
                     (state == ST_WR || state == ST_RDW)  ? (cnt == 2'd0) : 1'b1;
  assign accept    = bus.hsel & bus.htrans[1] & ready_int;
  // The counter only falls inside a state, so it still equals WS on entry.
  assign first     = (cnt == WS);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    en_int     = 1'b0;
    we_int     = 1'b0;
    resp_int   = HRESP_OKAY;
    capture    = 1'b0;
    case (state)
      ST_WR: begin
        en_int = first;
        we_int = first;
      end
      ST_RD: begin
        en_int     = 1'b1;
        state_next = ST_RDW;
      end
      ST_RDW:  capture = first;
      ST_ERR1: begin
        resp_int   = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      ST_ERR2: resp_int = HRESP_ERROR;
      default: ;
    endcase
    if ((state == ST_WR || state == ST_RDW) && cnt != 2'd0)
      cnt_next = cnt - 2'd1;
    // Any cycle that completes a transfer doubles as the next address phase.
    if (ready_int) begin
      state_next = ST_IDLE;
      if (accept) begin
        cnt_next = WS;
        if (align_err)       state_next = ST_ERR1;
        else if (bus.hwrite) state_next = ST_WR;
        else                 state_next = ST_RD;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      cnt     <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) rdata_q <= mem_rdata;
      if (accept) begin
        addr_q  <= bus.haddr[ADDR_WIDTH-1:2];
        wstrb_q <= strb;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the FSM clears.
  assign mem_en     = ~hreset & en_int;
  assign mem_we     = ~hreset & we_int;
  assign mem_wstrb  = (mem_en & mem_we) ? wstrb_q : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = bus.hwdata;
  assign bus.hready = hreset | ready_int;
  assign bus.hresp  = ~hreset & resp_int;
  assign bus.hrdata = hreset ? 32'h0 : (capture ? mem_rdata : rdata_q);

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: a zero-wait and a two-wait instance share one
// pipelined master; a scoreboard checks every completed data phase.
module tb_ahbl_sram_slave;
  import ahbl_pkg::*;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [3:0]  wstrb;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  wstrb;
    int          waits;
  } exp_t;

  logic        hclk, hreset, use_ws2;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;

  ahbl_sram_slave_if bus0 ();
  ahbl_sram_slave_if bus2 ();

  assign bus0.hsel = hsel & ~use_ws2;
  assign bus2.hsel = hsel & use_ws2;
  assign bus0.haddr = haddr;         assign bus2.haddr = haddr;
  assign bus0.hwrite = hwrite;       assign bus2.hwrite = hwrite;
  assign bus0.hsize = hsize;         assign bus2.hsize = hsize;
  assign bus0.htrans = htrans;       assign bus2.htrans = htrans;
  assign bus0.hwdata = hwdata;       assign bus2.hwdata = hwdata;
  assign bus0.hburst = 3'b001;       assign bus2.hburst = 3'b001;
  assign bus0.hprot = 4'b0011;       assign bus2.hprot = 4'b0011;
  assign bus0.hmastrlock = 1'b0;     assign bus2.hmastrlock = 1'b0;

  logic        m0_en, m0_we, m2_en, m2_we;
  logic [9:0]  m0_addr, m2_addr;
  logic [3:0]  m0_wstrb, m2_wstrb;
  logic [31:0] m0_wdata, m2_wdata, m0_rdata, m2_rdata;
  logic [31:0] mem0 [1024];
  logic [31:0] mem2 [1024];

  ahbl_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .bus(bus0),
    .mem_en(m0_en), .mem_we(m0_we), .mem_addr(m0_addr),
    .mem_wstrb(m0_wstrb), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
  );

  ahbl_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .bus(bus2),
    .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr),
    .mem_wstrb(m2_wstrb), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata)
  );

  // SRAM models: read data appears one cycle after the strobe.
  always @(posedge hclk) begin
    if (m0_en) begin
      if (m0_we) begin
        for (int b = 0; b < 4; b++)
          if (m0_wstrb[b]) mem0[m0_addr][b*8 +: 8] <= m0_wdata[b*8 +: 8];
      end else m0_rdata <= mem0[m0_addr];
    end
  end

  always @(posedge hclk) begin
    if (m2_en) begin
      if (m2_we) begin
        for (int b = 0; b < 4; b++)
          if (m2_wstrb[b]) mem2[m2_addr][b*8 +: 8] <= m2_wdata[b*8 +: 8];
      end else m2_rdata <= mem2[m2_addr];
    end
  end

  logic        s_ready, s_resp, s_en, s_we, s_hsel;
  logic [31:0] s_rdata, s_wdata;
  logic [9:0]  s_addr;
  logic [3:0]  s_wstrb;
  assign s_ready = use_ws2 ? bus2.hready : bus0.hready;
  assign s_resp  = use_ws2 ? bus2.hresp  : bus0.hresp;
  assign s_rdata = use_ws2 ? bus2.hrdata : bus0.hrdata;
  assign s_en    = use_ws2 ? m2_en       : m0_en;
  assign s_we    = use_ws2 ? m2_we       : m0_we;
  assign s_addr  = use_ws2 ? m2_addr     : m0_addr;
  assign s_wstrb = use_ws2 ? m2_wstrb    : m0_wstrb;
  assign s_wdata = use_ws2 ? m2_wdata    : m0_wdata;
  assign s_hsel  = use_ws2 ? bus2.hsel   : bus0.hsel;

  vec_t        vec [21];
  exp_t        exp_q [$];
  exp_t        cur;
  logic [31:0] ref_mem [2][1024];
  logic        in_dp, mon_on, last_ready;
  int          waits, en_cnt, errors, checks;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    int   s, ws;
    logic [9:0] w;
    s  = use_ws2 ? 1 : 0;
    ws = use_ws2 ? 2 : 0;
    w  = vec[i].addr[11:2];
    e.wr    = vec[i].wr;
    e.addr  = vec[i].addr;
    e.wdata = vec[i].wdata;
    e.err   = vec[i].err;
    e.wstrb = vec[i].wstrb;
    e.rdata = ref_mem[s][w];
    e.waits = vec[i].err ? 1 : (vec[i].wr ? ws : 1 + ws);
    if (!vec[i].err && vec[i].wr)
      for (int b = 0; b < 4; b++)
        if (vec[i].wstrb[b]) ref_mem[s][w][b*8 +: 8] = vec[i].wdata[b*8 +: 8];
    exp_q.push_back(e);
  endtask

  // Sampled at the falling edge, well away from the active edge.
  task automatic check_output();
    if (!mon_on) return;
    if (in_dp) begin
      if (s_en) begin
        en_cnt++;
        check("mem_we", 32'(s_we), 32'(cur.wr));
        check("mem_addr", 32'(s_addr), 32'(cur.addr[11:2]));
        if (cur.wr) begin
          check("mem_wstrb", 32'(s_wstrb), 32'(cur.wstrb));
          check("mem_wdata", s_wdata, cur.wdata);
        end else check("rd_wstrb", 32'(s_wstrb), 32'h0);
      end
      if (!s_ready) begin
        waits++;
        if (cur.err && waits == 1) check("err1_hresp", 32'(s_resp), 32'h1);
      end else begin
        check("wait_cycles", 32'(waits), 32'(cur.waits));
        check("hresp", 32'(s_resp), 32'(cur.err));
        check("mem_en_count", 32'(en_cnt), cur.err ? 32'h0 : 32'h1);
        if (!cur.wr && !cur.err) check("hrdata", s_rdata, cur.rdata);
        in_dp = 1'b0;
      end
    end else check("idle_quiet", 32'({s_resp, s_en, s_ready}), 32'h1);
    if (s_ready && s_hsel && htrans[1]) begin
      if (exp_q.size() == 0) check("unexpected_accept", 32'h1, 32'h0);
      else begin
        cur    = exp_q.pop_front();
        in_dp  = 1'b1;
        waits  = 0;
        en_cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge hclk);
    check_output();
    last_ready = s_ready;
    @(posedge hclk);
    #1;
  endtask

  // Pipelined master: next address phase overlaps the current data phase.
  task automatic applyStimulus(input int lo, input int hi);
    int guard;
    for (int i = lo; i <= hi; i++) begin
      hsel   = 1'b1;
      htrans = HTRANS_NONSEQ;
      haddr  = vec[i].addr;
      hwrite = vec[i].wr;
      hsize  = vec[i].size;
      push_exp(i);
      guard = 0;
      forever begin
        tick();
        if (last_ready) break;
        guard++;
        if (guard > 10) begin
          check("accept_timeout", 32'h1, 32'h0);
          break;
        end
      end
      hwdata = vec[i].wdata;
    end
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || in_dp) && guard < 30) begin
      tick();
      guard++;
    end
    check("drain", 32'(exp_q.size()) + 32'(in_dp), 32'h0);
    tick();
  endtask

  initial begin
    vec[0]  = '{1'b1, HSIZE_WORD, 32'h010, 32'hDEADBEEF, 1'b0, 4'hF};
    vec[1]  = '{1'b0, HSIZE_WORD, 32'h010, 32'h0,        1'b0, 4'hF};
    vec[2]  = '{1'b1, HSIZE_BYTE, 32'h013, 32'hAA000000, 1'b0, 4'b1000};
    vec[3]  = '{1'b1, HSIZE_HALF, 32'h016, 32'h55660000, 1'b0, 4'b1100};
    vec[4]  = '{1'b0, HSIZE_WORD, 32'h010, 32'h0,        1'b0, 4'hF};
    vec[5]  = '{1'b1, HSIZE_WORD, 32'h002, 32'h11111111, 1'b1, 4'h0};
    vec[6]  = '{1'b0, 3'd3,       32'h000, 32'h0,        1'b1, 4'h0};
    vec[7]  = '{1'b1, HSIZE_WORD, 32'h000, 32'h12345678, 1'b0, 4'hF};
    vec[8]  = '{1'b0, HSIZE_BYTE, 32'h001, 32'h0,        1'b0, 4'h2};
    vec[9]  = '{1'b1, HSIZE_HALF, 32'h008, 32'h0000CAFE, 1'b0, 4'b0011};
    vec[10] = '{1'b1, HSIZE_HALF, 32'h00A, 32'hBEEF0000, 1'b0, 4'b1100};
    vec[11] = '{1'b1, HSIZE_BYTE, 32'h009, 32'h00001100, 1'b0, 4'b0010};
    vec[12] = '{1'b1, HSIZE_HALF, 32'h005, 32'h22222222, 1'b1, 4'h0};
    vec[13] = '{1'b0, HSIZE_WORD, 32'h008, 32'h0,        1'b0, 4'hF};
    vec[14] = '{1'b1, HSIZE_WORD, 32'h020, 32'hA5A55A5A, 1'b0, 4'hF};
    vec[15] = '{1'b0, HSIZE_WORD, 32'h020, 32'h0,        1'b0, 4'hF};
    vec[16] = '{1'b1, HSIZE_BYTE, 32'h022, 32'h00770000, 1'b0, 4'b0100};
    vec[17] = '{1'b0, HSIZE_WORD, 32'h020, 32'h0,        1'b0, 4'hF};
    vec[18] = '{1'b0, HSIZE_WORD, 32'h003, 32'h0,        1'b1, 4'h0};
    vec[19] = '{1'b1, HSIZE_WORD, 32'h000, 32'h0BADF00D, 1'b0, 4'hF};
    vec[20] = '{1'b0, HSIZE_WORD, 32'h000, 32'h0,        1'b0, 4'hF};
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 1024; w++) ref_mem[s][w] = 32'h0;

    errors = 0; checks = 0; waits = 0; en_cnt = 0;
    in_dp = 1'b0; mon_on = 1'b0; last_ready = 1'b0; use_ws2 = 1'b0;
    hreset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 32'h0;
    hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h0;

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hready0", 32'({bus0.hready, bus0.hresp, m0_en, m0_we}), 32'h8);
    check("rst_hready2", 32'({bus2.hready, bus2.hresp, m2_en, m2_we}), 32'h8);
    check("rst_hrdata0", bus0.hrdata, 32'h0);
    check("rst_mem_wstrb2", 32'(m2_wstrb), 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    mon_on = 1'b1;

    applyStimulus(0, 13);
    drain();

    // IDLE/BUSY with select, and NONSEQ without select, are zero-wait no-ops.
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h010;
    repeat (2) begin
      tick();
      check("busy_hready", 32'(last_ready), 32'h1);
    end
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    tick();
    check("unsel_hready", 32'(last_ready), 32'h1);
    htrans = HTRANS_IDLE;

    use_ws2 = 1'b1;
    applyStimulus(14, 18);
    drain();

    // Reset lands in the read's strobe cycle; the read must be abandoned.
    mon_on = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h020; hwrite = 1'b0; hsize = HSIZE_WORD;
    tick();
    hsel = 1'b0; htrans = HTRANS_IDLE;
    hreset = 1'b1;
    @(negedge hclk);
    check("mid_rst_state", 32'({bus2.hready, bus2.hresp, m2_en}), 32'h4);
    check("mid_rst_hrdata", bus2.hrdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("post_rst_state", 32'({bus2.hready, bus2.hresp, m2_en}), 32'h4);
    check("post_rst_hrdata", bus2.hrdata, 32'h0);
    @(posedge hclk);
    #1;
    in_dp  = 1'b0;
    mon_on = 1'b1;

    applyStimulus(19, 20);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
